ffa2_stream_filter: RTL and testbench

- Parametrised successor to the 2-parallel fast-FIR (FFA) datapath.
- Consumes one pair of input samples per 4-phase req/ack transaction and produces one pair of filtered output samples per 4-phase transaction.
- Uses three sub-filters (H0, H1, H0+H1) of NR_STAGES/2 taps, with internal delay lines, post-add and rounding/saturation.
- Adds three features the earlier datapath lacks: a one-entry output buffer with backpressure, a runtime coefficient load, and a selectable scaling shift.

---
 rtl/ffa2_stream_filter.sv | 198 +++++++++++++++++++
 tb/tb_ffa2_stream_filter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffa2_stream_filter.sv
// ffa2_stream_filter: 2-parallel fast-FIR with 4-phase handshakes,
// a one-entry output buffer, runtime coefficient load and Q scaling.
module ffa2_stream_filter #(
    parameter int NR_STAGES = 32,
    parameter int DWIDTH    = 16,
    parameter int DDWIDTH   = 2*DWIDTH,
    parameter int CWIDTH    = NR_STAGES*DWIDTH,
    parameter int SHIFT     = DWIDTH-1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_in,
    output logic               ack_in,
    input  logic [DDWIDTH-1:0] data_in,
    input  logic               req_out,
    output logic               ack_out,
    output logic [DDWIDTH-1:0] data_out,
    input  logic [CWIDTH-1:0]  h_in,
    input  logic               coef_load
);

    localparam int M  = NR_STAGES/2;
    localparam int PW = DWIDTH+1;
    localparam int AW = 2*DWIDTH + $clog2(NR_STAGES) + 2;

    localparam logic signed [AW-1:0] HALF =
        AW'(1) <<< (SHIFT-1);
    localparam logic signed [AW-1:0] MAXV =
        (AW'(1) <<< (DWIDTH-1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV =
        -(AW'(1) <<< (DWIDTH-1));

    typedef enum logic [1:0] {
        S_IDLE, S_COMPUTE, S_WRITE, S_HOLD
    } in_state_t;

    typedef enum logic [1:0] {
        S_EMPTY, S_FULL, S_ACKED
    } out_state_t;

    in_state_t  in_st;
    out_state_t out_st;

    logic [CWIDTH-1:0]        coef;
    logic signed [DWIDTH-1:0] dl0 [M];
    logic signed [DWIDTH-1:0] dl1 [M];

    logic signed [DWIDTH-1:0]   h0 [M];
    logic signed [DWIDTH-1:0]   h1 [M];
    logic signed [PW-1:0]       hs [M];
    logic signed [PW-1:0]       xs [M];
    logic signed [2*DWIDTH-1:0] p0 [M];
    logic signed [2*DWIDTH-1:0] p1 [M];
    logic signed [2*PW-1:0]     p2 [M];

    logic signed [AW-1:0] a_comb, b_comb, c_comb;
    logic signed [AW-1:0] sum_a, sum_b, sum_c, bz;
    logic signed [AW-1:0] y0_acc, y1_acc;
    logic [DDWIDTH-1:0]   buf_q;

    logic buf_free;
    logic capture;
    logic buf_write;

    for (genvar j = 0; j < M; j++) begin : g_tap
        assign h0[j] = coef[(2*j)*DWIDTH +: DWIDTH];
        assign h1[j] = coef[(2*j+1)*DWIDTH +: DWIDTH];
        assign hs[j] = PW'(h0[j]) + PW'(h1[j]);
        assign xs[j] = PW'(dl0[j]) + PW'(dl1[j]);
        assign p0[j] = h0[j] * dl0[j];
        assign p1[j] = h1[j] * dl1[j];
        assign p2[j] = hs[j] * xs[j];
    end

    // Sub-filter sums H0*x0, H1*x1 and (H0+H1)*(x0+x1)
    always_comb begin
        a_comb = '0;
        b_comb = '0;
        c_comb = '0;
        for (int j = 0; j < M; j++) begin
            a_comb = a_comb + AW'(p0[j]);
            b_comb = b_comb + AW'(p1[j]);
            c_comb = c_comb + AW'(p2[j]);
        end
    end

    assign y0_acc = sum_a + bz;
    assign y1_acc = sum_c - sum_a - sum_b;

    function automatic logic [DWIDTH-1:0] rnd_sat(
        input logic signed [AW-1:0] acc
    );
        logic signed [AW-1:0] r;
        r = (acc + HALF) >>> SHIFT;
        if (r > MAXV)
            return MAXV[DWIDTH-1:0];
        else if (r < MINV)
            return MINV[DWIDTH-1:0];
        else
            return r[DWIDTH-1:0];
    endfunction

    // A draining buffer counts as free so capture can overlap it
    assign buf_free = (out_st == S_EMPTY) ||
                      (out_st == S_ACKED && !req_out);
    assign capture   = (in_st == S_IDLE) && req_in && buf_free;
    assign buf_write = (in_st == S_WRITE);

    // Input handshake, delay lines, sub-filter pipeline, buffer write
    always_ff @(posedge clk) begin
        if (rst) begin
            in_st  <= S_IDLE;
            ack_in <= 1'b0;
            coef   <= '0;
            sum_a  <= '0;
            sum_b  <= '0;
            sum_c  <= '0;
            bz     <= '0;
            buf_q  <= '0;
            for (int j = 0; j < M; j++) begin
                dl0[j] <= '0;
                dl1[j] <= '0;
            end
        end else begin
            unique case (in_st)
                S_IDLE: begin
                    if (capture) begin
                        dl0[0] <= data_in[DWIDTH-1:0];
                        dl1[0] <= data_in[DDWIDTH-1:DWIDTH];
                        for (int j = 1; j < M; j++) begin
                            dl0[j] <= dl0[j-1];
                            dl1[j] <= dl1[j-1];
                        end
                        in_st <= S_COMPUTE;
                    end else if (coef_load) begin
                        coef <= h_in;
                    end
                end
                S_COMPUTE: begin
                    sum_a <= a_comb;
                    sum_b <= b_comb;
                    sum_c <= c_comb;
                    in_st <= S_WRITE;
                end
                S_WRITE: begin
                    buf_q  <= {rnd_sat(y1_acc), rnd_sat(y0_acc)};
                    bz     <= sum_b;
                    ack_in <= 1'b1;
                    in_st  <= S_HOLD;
                end
                S_HOLD: begin
                    if (!req_in) begin
                        ack_in <= 1'b0;
                        in_st  <= S_IDLE;
                    end
                end
                default: begin
                    ack_in <= 1'b0;
                    in_st  <= S_IDLE;
                end
            endcase
        end
    end

    // Output buffer state and pull-side handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_st   <= S_EMPTY;
            ack_out  <= 1'b0;
            data_out <= '0;
        end else begin
            unique case (out_st)
                S_EMPTY: begin
                    if (buf_write)
                        out_st <= S_FULL;
                end
                S_FULL: begin
                    if (req_out) begin
                        data_out <= buf_q;
                        ack_out  <= 1'b1;
                        out_st   <= S_ACKED;
                    end
                end
                S_ACKED: begin
                    if (!req_out) begin
                        ack_out <= 1'b0;
                        out_st  <= S_EMPTY;
                    end
                end
                default: begin
                    ack_out <= 1'b0;
                    out_st  <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffa2_stream_filter.sv
// tb_ffa2_stream_filter: directed and random checks of the 2-parallel
// filter against a direct-form reference with identical rounding.
module tb_ffa2_stream_filter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SH = 15;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic        ack_in;
    logic [31:0] data_in;
    logic        req_out;
    logic        ack_out;
    logic [31:0] data_out;
    logic [63:0] h_in;
    logic        coef_load;

    int checks = 0;
    int fails  = 0;

    int          model_h [N];
    longint      hist [$];
    logic [31:0] expq [$];

    always #5 clk = ~clk;

    ffa2_stream_filter #(
        .NR_STAGES(N),
        .DWIDTH(DW),
        .SHIFT(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_in(req_in),
        .ack_in(ack_in),
        .data_in(data_in),
        .req_out(req_out),
        .ack_out(ack_out),
        .data_out(data_out),
        .h_in(h_in),
        .coef_load(coef_load)
    );

    function automatic logic [15:0] rs(input longint acc);
        longint r;
        r = (acc + (longint'(1) << (SH-1))) >>> SH;
        if (r > 32767) return 16'h7fff;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    // y(n) = sum h[i] * x(n-i), history newest first
    function automatic longint conv();
        longint s = 0;
        for (int i = 0; i < N && i < hist.size(); i++)
            s += longint'(model_h[i]) * hist[i];
        return s;
    endfunction

    function automatic logic sig(input int w);
        return (w == 0) ? ack_in : ack_out;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_for(input int w, input logic v,
                            input string name);
        int n = 0;
        while (sig(w) !== v && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            checks++;
            fails++;
            $display("FAIL timeout_%s got=%b exp=%b", name, sig(w), v);
        end
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] x1);
        wait_for(0, 1'b0, "send_idle");
        data_in = {x1, x0};
        req_in = 1'b1;
        wait_for(0, 1'b1, "send_ack");
        req_in = 1'b0;
        wait_for(0, 1'b0, "send_rel");
    endtask

    task automatic recv(output logic [31:0] got);
        req_out = 1'b1;
        wait_for(1, 1'b1, "recv_ack");
        got = data_out;
        req_out = 1'b0;
        wait_for(1, 1'b0, "recv_rel");
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        wait_for(0, 1'b0, "load_idle");
        h_in = {d, c, b, a};
        coef_load = 1'b1;
        model_h[0] = int'($signed(a));
        model_h[1] = int'($signed(b));
        model_h[2] = int'($signed(c));
        model_h[3] = int'($signed(d));
        @(negedge clk);
        coef_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) model_h[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Capture, then pulse coef_load while the DUT is in COMPUTE
    task automatic send_glitch(input logic [15:0] x0,
                               input logic [15:0] x1,
                               input logic [63:0] hbad);
        wait_for(0, 1'b0, "gl_idle");
        data_in = {x1, x0};
        req_in = 1'b1;
        @(negedge clk);
        h_in = hbad;
        coef_load = 1'b1;
        @(negedge clk);
        coef_load = 1'b0;
        wait_for(0, 1'b1, "gl_ack");
        req_in = 1'b0;
        wait_for(0, 1'b0, "gl_rel");
    endtask

    // Reference model and per-cycle output compare
    initial begin : monitor
        logic        pai;
        logic        pao;
        logic [31:0] held;
        logic [31:0] e;
        logic [15:0] y0;
        logic [15:0] y1;
        pai = 1'b0;
        pao = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hist.delete();
                expq.delete();
                pai = 1'b0;
                pao = 1'b0;
            end else begin
                if (ack_in && !pai) begin
                    hist.push_front(longint'($signed(data_in[15:0])));
                    if (hist.size() > N) void'(hist.pop_back());
                    y0 = rs(conv());
                    hist.push_front(longint'($signed(data_in[31:16])));
                    if (hist.size() > N) void'(hist.pop_back());
                    y1 = rs(conv());
                    expq.push_back({y1, y0});
                end
                if (ack_out && !pao) begin
                    checks++;
                    if (expq.size() == 0) begin
                        fails++;
                        $display("FAIL out_unexpected got=%h exp=none",
                                 data_out);
                    end else begin
                        e = expq.pop_front();
                        if (data_out !== e) begin
                            fails++;
                            $display("FAIL model_out got=%h exp=%h",
                                     data_out, e);
                        end
                    end
                    held = data_out;
                end else if (ack_out) begin
                    checks++;
                    if (data_out !== held) begin
                        fails++;
                        $display("FAIL out_stable got=%h exp=%h",
                                 data_out, held);
                    end
                end
                pai = ack_in;
                pao = ack_out;
            end
        end
    end

    initial begin : stim
        logic [31:0] g;
        rst = 1'b1;
        req_in = 1'b0;
        req_out = 1'b0;
        data_in = '0;
        h_in = '0;
        coef_load = 1'b0;
        for (int i = 0; i < N; i++) model_h[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack_in", {31'd0, ack_in}, 32'd0);
        check("rst_ack_out", {31'd0, ack_out}, 32'd0);
        check("rst_data_out", data_out, 32'd0);

        // impulse; second IDLE load overrides the first
        load(16'h7fff, 16'h0, 16'h0, 16'h0);
        load(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send(16'h4000, 16'h0);
        recv(g);
        check("imp_0", g, 32'h1000_2000);
        send(16'h0, 16'h0);
        recv(g);
        check("imp_1", g, 32'h0400_0800);
        send(16'h0, 16'h0);
        recv(g);
        check("imp_2", g, 32'h0000_0000);

        // coef_load in COMPUTE ignored, in IDLE honoured
        do_reset();
        load(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send_glitch(16'h4000, 16'h0, {4{16'h7fff}});
        recv(g);
        check("glitch_0", g, 32'h1000_2000);
        send(16'h0, 16'h0);
        recv(g);
        check("glitch_1", g, 32'h0400_0800);
        load(16'h2000, 16'h1000, 16'h0, 16'h0);
        send(16'h4000, 16'h0);
        recv(g);
        check("newh_0", g, 32'h0800_1000);

        // positive saturation
        do_reset();
        load(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
        for (int i = 0; i < 3; i++) begin
            send(16'h7fff, 16'h7fff);
            recv(g);
            if (i > 0) check("sat_pos", g, 32'h7fff_7fff);
        end

        // negative saturation
        do_reset();
        load(16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff);
        for (int i = 0; i < 3; i++) begin
            send(16'h8000, 16'h8000);
            recv(g);
            if (i > 0) check("sat_neg", g, 32'h8000_8000);
        end

        // backpressure: second pair stalls until the first drains
        do_reset();
        load(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send(16'h4000, 16'h0);
        fork
            send(16'h2000, 16'h4000);
            begin
                logic [31:0] g1;
                repeat (10) begin
                    @(negedge clk);
                    check("bp_stall", {31'd0, ack_in}, 32'd0);
                end
                recv(g1);
                check("bp_first", g1, 32'h1000_2000);
            end
        join
        recv(g);
        check("bp_second", g, 32'h2c00_1800);

        // reset while in HOLD with a full buffer
        data_in = {16'h0, 16'h4000};
        req_in = 1'b1;
        wait_for(0, 1'b1, "mid_ack");
        rst = 1'b1;
        for (int i = 0; i < N; i++) model_h[i] = 0;
        @(posedge clk);
        #1;
        check("mid_ack_in", {31'd0, ack_in}, 32'd0);
        check("mid_ack_out", {31'd0, ack_out}, 32'd0);
        check("mid_data_out", data_out, 32'd0);
        @(negedge clk);
        req_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send(16'h4000, 16'h0);
        recv(g);
        check("post_rst_0", g, 32'h1000_2000);
        send(16'h0, 16'h0);
        recv(g);
        check("post_rst_1", g, 32'h0400_0800);
        send(16'h0, 16'h0);
        recv(g);
        check("post_rst_2", g, 32'h0000_0000);

        // random regression against the reference model
        do_reset();
        load(16'($urandom_range(0, 16'h7fff)) - 16'h4000,
             16'($urandom_range(0, 16'h7fff)) - 16'h4000,
             16'($urandom_range(0, 16'h7fff)) - 16'h4000,
             16'($urandom_range(0, 16'h7fff)) - 16'h4000);
        fork
            for (int i = 0; i < 1000; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(16'($urandom), 16'($urandom));
            end
            for (int i = 0; i < 1000; i++) begin
                logic [31:0] gr;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                recv(gr);
            end
        join
        repeat (2) @(negedge clk);
        check("rand_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
